// File: rtl/vending_controller.sv
// Purchase controller for the vending machine: credit accumulation, product
// selection, dispense and change return, with registered outputs for display_module.
module vending_controller #(
  parameter int PRICE_A         = 10,
  parameter int PRICE_B         = 15,
  parameter int PRICE_C         = 20,
  parameter int MAX_AMOUNT      = 31,
  parameter int DISPENSE_CYCLES = 4,
  parameter int CHANGE_CYCLES   = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       coin_5,
  input  logic       coin_10,
  input  logic [1:0] product_sel,
  input  logic       cancel,
  output logic [4:0] current_amount,
  output logic [2:0] current_state,
  output logic [1:0] product_out,
  output logic [4:0] change_out,
  output logic       coin_reject,
  output logic       insufficient
);

  localparam int DATA_W = 5;

  localparam logic [2:0] S_IDLE     = 3'b000;
  localparam logic [2:0] S_DEPOSIT  = 3'b001;
  localparam logic [2:0] S_SELECT   = 3'b010;
  localparam logic [2:0] S_DISPENSE = 3'b011;
  localparam logic [2:0] S_CHANGE   = 3'b100;

  localparam logic [7:0] DISPENSE_LAST = 8'(DISPENSE_CYCLES - 1);
  localparam logic [7:0] CHANGE_LAST   = 8'(CHANGE_CYCLES - 1);

  logic [1:0]        sel_q;
  logic [7:0]        dwell;
  logic              coin_any;
  logic [DATA_W:0]   coin_sum;
  logic              coin_fits;
  logic [DATA_W-1:0] price;

  function automatic logic [DATA_W:0] coin_value(input logic c5, input logic c10);
    coin_value = (c5 ? (DATA_W+1)'(5) : '0) + (c10 ? (DATA_W+1)'(10) : '0);
  endfunction

  function automatic logic [DATA_W-1:0] price_of(input logic [1:0] sel);
    case (sel)
      2'b01:   price_of = DATA_W'(PRICE_A);
      2'b10:   price_of = DATA_W'(PRICE_B);
      2'b11:   price_of = DATA_W'(PRICE_C);
      default: price_of = '1;
    endcase
  endfunction

  // Six-bit sum so an overflowing deposit is detected rather than wrapped.
  assign coin_any  = coin_5 | coin_10;
  assign coin_sum  = {1'b0, current_amount} + coin_value(coin_5, coin_10);
  assign coin_fits = (coin_sum <= (DATA_W+1)'(MAX_AMOUNT));
  assign price     = price_of(sel_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      current_state  <= S_IDLE;
      current_amount <= '0;
      product_out    <= '0;
      change_out     <= '0;
      coin_reject    <= 1'b0;
      insufficient   <= 1'b0;
      sel_q          <= '0;
      dwell          <= '0;
    end else begin
      coin_reject  <= 1'b0;
      insufficient <= 1'b0;
      case (current_state)
        S_IDLE: begin
          if (coin_any) begin
            if (coin_fits) begin
              current_amount <= coin_sum[DATA_W-1:0];
              current_state  <= S_DEPOSIT;
            end else begin
              coin_reject <= 1'b1;
            end
          end
        end
        S_DEPOSIT: begin
          // Cancel beats selection beats coins; losing coins are refused.
          if (cancel) begin
            current_state <= S_CHANGE;
            change_out    <= current_amount;
            product_out   <= '0;
            dwell         <= '0;
            coin_reject   <= coin_any;
          end else if (product_sel != 2'b00) begin
            sel_q         <= product_sel;
            current_state <= S_SELECT;
            coin_reject   <= coin_any;
          end else if (coin_any) begin
            if (coin_fits) current_amount <= coin_sum[DATA_W-1:0];
            else           coin_reject    <= 1'b1;
          end
        end
        S_SELECT: begin
          coin_reject <= coin_any;
          if (current_amount >= price) begin
            product_out    <= sel_q;
            change_out     <= current_amount - price;
            current_amount <= current_amount - price;
            dwell          <= '0;
            current_state  <= S_DISPENSE;
          end else begin
            insufficient  <= 1'b1;
            current_state <= S_DEPOSIT;
          end
        end
        S_DISPENSE: begin
          coin_reject <= coin_any;
          if (dwell == DISPENSE_LAST) begin
            product_out   <= '0;
            dwell         <= '0;
            current_state <= (change_out != '0) ? S_CHANGE : S_IDLE;
          end else begin
            dwell <= dwell + 8'd1;
          end
        end
        S_CHANGE: begin
          coin_reject <= coin_any;
          if (dwell == CHANGE_LAST) begin
            current_amount <= '0;
            change_out     <= '0;
            product_out    <= '0;
            dwell          <= '0;
            current_state  <= S_IDLE;
          end else begin
            dwell <= dwell + 8'd1;
          end
        end
        default: current_state <= S_IDLE;
      endcase
    end
  end

endmodule
